// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for the sequential shift-add multiplier.
// Latency: none, wires only.
// Backpressure: none; the requester watches busy/done.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 sign_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   p;
  logic                 busy;
  logic                 done;

  // Requester side: issues operands, observes the result.
  modport master (
    output start, sign_mode, a, b,
    input  p, busy, done
  );

  // Multiplier side: samples operands, drives the result.
  modport slave (
    input  start, sign_mode, a, b,
    output p, busy, done
  );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier, unsigned or two's-complement.
// Latency: done pulses WIDTH+2 edges after the accepting edge; back-to-back period WIDTH+3.
// Backpressure: start is ignored while busy; nothing is queued.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  seq_multiplier_if.slave mif
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 done_q, done_d;
  logic                 busy;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     shift_in;

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one CALC cycle per operand bit, then sign fix-up and completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mif.start) state_d = CALC;
      CALC:    if (cnt_q == CW'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs derived from state: busy covers every non-idle state.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which fits unsigned.
  always_comb begin
    a_mag = (mif.sign_mode && mif.a[WIDTH-1]) ? (~mif.a + 1'b1) : mif.a;
    b_mag = (mif.sign_mode && mif.b[WIDTH-1]) ? (~mif.b + 1'b1) : mif.b;
  end

  // One shift-add step: conditional add into the high half keeping the carry, then shift right.
  always_comb begin
    sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    shift_in = {sum, prod_q[WIDTH-1:0]};
  end

  // Datapath next-state: load on accept, iterate in CALC, negate in FIX, hold otherwise.
  always_comb begin
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    done_d  = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (mif.start) begin
          prod_d  = {{WIDTH{1'b0}}, b_mag};
          mcand_d = a_mag;
          cnt_d   = CW'(WIDTH);
          neg_d   = mif.sign_mode & (mif.a[WIDTH-1] ^ mif.b[WIDTH-1]);
        end
      end
      CALC: begin
        prod_d = shift_in[2*WIDTH:1];
        cnt_d  = cnt_q - 1'b1;
      end
      FIX: begin
        // Negating zero yields zero, so a zero product never comes out negative.
        if (neg_q) prod_d = ~prod_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers; done is registered so it lands in the cycle after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign mif.p    = prod_q;
  assign mif.busy = busy;
  assign mif.done = done_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH 8, 16 and 32 against an arithmetic reference.
// Latency: checks done at WIDTH+2 edges after accept and WIDTH+3 back-to-back spacing.
// Backpressure: checks that start pulses while busy are ignored.
module tb_seq_multiplier;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  seq_multiplier_if #(.WIDTH(8))  if8  ();
  seq_multiplier_if #(.WIDTH(16)) if16 ();
  seq_multiplier_if #(.WIDTH(32)) if32 ();

  seq_multiplier #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .mif(if8));
  seq_multiplier #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .mif(if16));
  seq_multiplier #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .mif(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: extend both operands to 128 bits per mode, multiply, keep 2*w bits.
  function automatic logic [127:0] ref_mul(int w, bit sm, logic [63:0] a, logic [63:0] b);
    logic [127:0] xa, xb, mask;
    xa = (sm && a[w-1]) ? {128{1'b1}} : '0;
    xb = (sm && b[w-1]) ? {128{1'b1}} : '0;
    for (int i = 0; i < w; i++) begin
      xa[i] = a[i];
      xb[i] = b[i];
    end
    mask = (128'd1 << (2 * w)) - 128'd1;
    return (xa * xb) & mask;
  endfunction

  function automatic logic [63:0] rnd_op(int w);
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic drive(int w, bit st, bit sm, logic [63:0] a, logic [63:0] b);
    case (w)
      8:  begin if8.start = st;  if8.sign_mode = sm;  if8.a = a[7:0];   if8.b = b[7:0];   end
      16: begin if16.start = st; if16.sign_mode = sm; if16.a = a[15:0]; if16.b = b[15:0]; end
      default: begin if32.start = st; if32.sign_mode = sm; if32.a = a[31:0]; if32.b = b[31:0]; end
    endcase
  endtask

  function automatic logic [63:0] get_p(int w);
    case (w)
      8:       return 64'(if8.p);
      16:      return 64'(if16.p);
      default: return 64'(if32.p);
    endcase
  endfunction

  function automatic logic get_busy(int w);
    case (w)
      8:       return if8.busy;
      16:      return if16.busy;
      default: return if32.busy;
    endcase
  endfunction

  function automatic logic get_done(int w);
    case (w)
      8:       return if8.done;
      16:      return if16.done;
      default: return if32.done;
    endcase
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation; optional start pulses sampled at edges 5 and 20 of the run.
  task automatic run_op(string tag, int w, bit sm, logic [63:0] a, logic [63:0] b,
                        logic [63:0] exp, bit pulse);
    int n;
    bit seen;
    @(negedge clk);
    drive(w, 1'b1, sm, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, sm, ~a, ~b);
    check({tag, " busy"}, get_busy(w), 1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pulse && (n == 4 || n == 19)) drive(w, 1'b1, ~sm, a ^ 64'h55, b + 64'd1);
      if (pulse && (n == 5 || n == 20)) drive(w, 1'b0, sm, a, b);
      if (get_done(w)) seen = 1'b1;
    end
    check({tag, " latency"}, n, w + 2);
    check({tag, " p"}, get_p(w), exp);
    @(posedge clk);
    @(negedge clk);
    check({tag, " done width"}, get_done(w), 0);
    check({tag, " idle"}, get_busy(w), 0);
    check({tag, " p hold"}, get_p(w), exp);
  endtask

  // start held high: results in order, done every w+3 cycles, nothing extra accepted.
  task automatic sweep(int w, int nops);
    logic [63:0]  a, b;
    bit           sm, pushed;
    logic [127:0] exp_q[$];
    int           cyc, last, ndone;
    @(negedge clk);
    a = rnd_op(w); b = rnd_op(w); sm = 1'(($urandom_range(0, 1)));
    drive(w, 1'b1, sm, a, b);
    cyc = 0; last = -1; ndone = 0; pushed = 1'b0;
    while (ndone < nops && cyc < nops * (w + 3) + 50) begin
      if (get_done(w)) begin
        check($sformatf("sweep%0d result avail", w), exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check($sformatf("sweep%0d p #%0d", w, ndone), get_p(w), exp_q.pop_front());
        if (last >= 0) check($sformatf("sweep%0d spacing", w), cyc - last, w + 3);
        last = cyc;
        ndone++;
      end
      if (ndone >= nops) break;
      if (!get_busy(w)) begin
        if (!pushed) begin
          exp_q.push_back(ref_mul(w, sm, a, b));
          pushed = 1'b1;
        end
      end else if (pushed) begin
        a = rnd_op(w); b = rnd_op(w); sm = 1'(($urandom_range(0, 1)));
        drive(w, 1'b1, sm, a, b);
        pushed = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    drive(w, 1'b0, sm, a, b);
    check($sformatf("sweep%0d count", w), ndone, nops);
    repeat (w + 5) @(negedge clk);
    check($sformatf("sweep%0d drained", w), exp_q.size(), 0);
    check($sformatf("sweep%0d idle", w), get_busy(w), 0);
  endtask

  initial begin
    int dn;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(16, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(32, 1'b1, 1'b0, 64'd3, 64'd4);

    // Reset state, with a start request on the 32-bit unit that must be ignored.
    @(posedge clk);
    @(negedge clk);
    check("rst p8", get_p(8), 0);
    check("rst busy8", get_busy(8), 0);
    check("rst p16", get_p(16), 0);
    check("rst done16", get_done(16), 0);
    check("rst p32", get_p(32), 0);
    check("rst busy32 start ignored", get_busy(32), 0);
    check("rst done32", get_done(32), 0);
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    rst = 1'b0;

    // Directed vectors with the published results.
    run_op("u32 max", 32, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0);
    run_op("s32 -3*7", 32, 1'b1, 64'hFFFFFFFD, 64'd7, 64'hFFFFFFFFFFFFFFEB, 1'b0);
    run_op("u32 -3*7", 32, 1'b0, 64'hFFFFFFFD, 64'd7, 64'h00000006FFFFFFEB, 1'b0);
    run_op("s8 min*min", 8, 1'b1, 64'h80, 64'h80, 64'h4000, 1'b0);
    run_op("s8 min*1", 8, 1'b1, 64'h80, 64'h01, 64'hFF80, 1'b0);
    run_op("s8 -1*-1", 8, 1'b1, 64'hFF, 64'hFF, 64'h0001, 1'b0);
    run_op("u16 max", 16, 1'b0, 64'hFFFF, 64'hFFFF, 64'hFFFE0001, 1'b0);
    run_op("s16 0*neg", 16, 1'b1, 64'h0, 64'h8001, 64'h0, 1'b0);
    run_op("s32 min*min", 32, 1'b1, 64'h80000000, 64'h80000000, 64'h4000000000000000, 1'b0);
    run_op("u32 start pulses", 32, 1'b0, 64'h12345678, 64'h9ABCDEF0,
           64'(ref_mul(32, 1'b0, 64'h12345678, 64'h9ABCDEF0)), 1'b1);

    // Asynchronous reset mid-operation, then a normal operation.
    @(negedge clk);
    drive(32, 1'b1, 1'b0, 64'h0BADF00D, 64'h1234);
    @(posedge clk);
    @(negedge clk);
    drive(32, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort p", get_p(32), 0);
    check("abort busy", get_busy(32), 0);
    check("abort done", get_done(32), 0);
    drive(32, 1'b1, 1'b0, 64'd5, 64'd5);
    @(posedge clk);
    @(negedge clk);
    check("start during rst", get_busy(32), 0);
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (get_done(32)) dn++;
    end
    check("no done after abort", dn, 0);
    run_op("u32 12*0", 32, 1'b0, 64'd12, 64'd0, 64'd0, 1'b0);

    // Randomized back-to-back sweeps.
    sweep(8, 12);
    sweep(16, 12);
    sweep(32, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset; asynchronous, active-high.
REQ-004 Port start  input  1  request; sampled on rising clk edge.
REQ-005 Port sign_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; sampled with start.
REQ-006 Port a  input  WIDTH  multiplicand; sampled with start.
REQ-007 Port b  input  WIDTH  multiplier; sampled with start.
REQ-008 Port p  output  2*WIDTH  product; registered.
REQ-009 Port busy  output  1  high while an operation is in progress.
REQ-010 Port done  output  1  one-cycle pulse marking p valid.

Function
REQ-011 States: IDLE, CALC, FIX, DONE, encoded in a registered state variable.
REQ-012 IDLE: start=1 accepted; a, b, sign_mode captured; next state CALC; start=0 stays IDLE.
REQ-013 On acceptance, signed mode: operands converted to magnitudes; result-negate flag = a[WIDTH-1] XOR b[WIDTH-1]; unsigned mode: operands used as-is, negate flag = 0.
REQ-014 Acceptance: product high half cleared, low half loaded with multiplier magnitude, iteration counter loaded with WIDTH.
REQ-015 CALC: one iteration per cycle; if product LSB = 1, high half + multiplicand magnitude (WIDTH+1-bit sum, carry kept); whole {carry, product} shifted right one bit in the same cycle; counter decremented.
REQ-016 CALC exits to FIX after exactly WIDTH iterations (counter reaches 0).
REQ-017 FIX: if negate flag set, product replaced by its 2*WIDTH-bit two's complement; otherwise unchanged; next state DONE.
REQ-018 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-019 busy=1 in CALC, FIX, DONE; busy=0 in IDLE.
REQ-020 Latency: done asserted at the (WIDTH+2)th rising edge after the edge accepting start.
REQ-021 p updates only inside an operation; after DONE, p holds the result until the next accepted start.
REQ-022 p internal value during CALC/FIX visible but not guaranteed meaningful; only valid when done=1 and after.
REQ-023 start while busy=1 ignored; operands not re-sampled; no queueing.
REQ-024 start held high continuously: new operation accepted in the IDLE cycle after each DONE; back-to-back period WIDTH+3 cycles.
REQ-025 Signed boundary: a = b = -2^(WIDTH-1) produces +2^(2*WIDTH-2) without overflow; magnitude 2^(WIDTH-1) representable in WIDTH unsigned bits.
REQ-026 Zero operand: full WIDTH iterations still executed; latency unchanged; result 0, never negative zero.
REQ-027 Unsigned result is exact over full range: (2^WIDTH-1)^2 fits in 2*WIDTH bits.

Reset
REQ-028 rst=1 immediately forces state IDLE, p=0, busy=0, done=0, counter=0, negate flag=0, regardless of clk.
REQ-029 rst asserted mid-operation aborts it; no done pulse; after release first start is accepted normally.
REQ-030 start sampled in the same edge that rst is high is ignored.

Verification
REQ-031 WIDTH=32, unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> done at edge 34, p=0xFFFFFFFE00000001, busy low next cycle.
REQ-032 WIDTH=32, signed, a=-3 (0xFFFFFFFD), b=7 -> p=0xFFFFFFFFFFFFFFEB (-21); same operands unsigned -> p=0x00000006FFFFFFEB.
REQ-033 WIDTH=8, signed, a=0x80, b=0x80 -> p=0x4000 at edge 10; a=0x80, b=0x01 -> p=0xFF80.
REQ-034 WIDTH=32, start pulsed again at edges 5 and 20 of a running operation -> ignored; first result unaffected; done pulses once.
REQ-035 Reset at cycle 10 of a WIDTH=32 operation -> p=0, busy=0 asynchronously, no done; then unsigned a=12, b=0 -> p=0 at latency 34.
REQ-036 Random sweep, WIDTH in {8,16,32}, both modes, start held high -> every result matches reference product, done spacing WIDTH+3 cycles.
